idct_8x8_engine: RTL
====================

// Module: idct_8x8_engine
// PURPOSE
//  Inverse 2-D 8x8 DCT engine: the decode counterpart of the forward DCT datapath.
//  Accepts 64 signed Q0 coefficients X[k1][k2] in raster order (k1 major) on a valid/ready
//  stream, buffers them, computes 64 pixels x[n1][n2] by direct MAC, and streams them out
//  in raster order (n1 major). Sits between the coefficient store and pixel reconstruction.
// PARAMETERS
//  COEF_W  16  signed input coefficient width
//  OUT_W   16  signed output pixel width (saturated)
//  ACC_W   40  signed accumulator width; must be >= COEF_W+24
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       coefficient valid
//  in_ready   out  1       engine accepts coefficient (LOAD state only)
//  in_coef    in   COEF_W  signed coefficient X[k1][k2], index = 8*k1+k2
//  out_valid  out  1       pixel valid
//  out_ready  in   1       downstream accepts pixel
//  out_pixel  out  OUT_W   signed pixel x[n1][n2], index = 8*n1+n2
//  out_last   out  1       high with out_valid on pixel index 63
//  busy       out  1       high in COMPUTE or OUTPUT
// BEHAVIOUR
//  Reset: state=LOAD, counters=0, acc=0; in_ready=1, out_valid=0, out_pixel=0, out_last=0, busy=0.
//  Table T[k][n] = round(256*a(k)*cos((2n+1)*k*pi/16)), a(0)=1/sqrt(2), a(k>0)=1; 9-bit signed
//   internal ROM (T[0][n]=181, T[1][0]=251). 2-D term = T[k1][n1]*T[k2][n2].
//  Math: x = sat_OUT_W((sum_{k1,k2} X*T[k1][n1]*T[k2][n2] + 2^17) >>> 18), arithmetic shift.
//  LOAD: in_ready=1; each in_valid&&in_ready writes buffer[cnt], cnt++. Handshake on
//   index 63 (cycle t) -> COMPUTE at t+1, in_ready=0 from t+1.
//  COMPUTE: one MAC per cycle, k=0..63; acc cleared on first MAC. 64 cycles per pixel.
//   Last handshake at t -> MACs t+1..t+64 -> out_valid=1 at t+65 with rounded/saturated result.
//  OUTPUT: out_pixel/out_last held stable while out_valid && !out_ready.
//   On out_valid&&out_ready: pixel idx<63 -> COMPUTE next pixel next cycle (out_valid=0);
//   idx==63 -> LOAD next cycle, in_ready=1, counters cleared. No pixel overlap with compute.
//  in_valid outside LOAD ignored (in_ready=0); no data captured.
//  Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  Throughput: 64*65 cycles + output stalls + 64 load cycles per block.
//  Async reset mid-operation: returns to reset values immediately; partial block discarded,
//   next block starts at coefficient index 0.
// TESTING
//  1. All 64 coefs 0 -> 64 pixels 0, out_last only on 64th, in_ready returns 1 after it.
//  2. X[0][0]=1024, rest 0 -> all 64 pixels = 128; first out_valid exactly 65 cycles after last in handshake.
//  3. X[0][0]=-1024 -> all pixels -128; X[0][0]=2^15-1 with OUT_W=8 -> all pixels 127 (saturate).
//  4. X[0][1]=256, rest 0 -> pixel (n1,0)=44 for all n1; pixels match golden model for all 64.
//  5. out_ready low 10 cycles on pixel 5 -> out_pixel/out_valid stable, no MAC progress; resumes.
//  6. rst_n low during COMPUTE pixel 20 -> outputs at reset values; new block of test 2 yields all 128.

Source files
------------

// File: rtl/idct_8x8_engine_if.sv
// Stream bundle for the 8x8 IDCT engine: coefficient input channel,
// pixel output channel and the busy status flag.
// master = the block feeding coefficients and consuming pixels; slave = the engine.
interface idct_8x8_engine_if #(
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_coef;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_pixel;
  logic                     out_last;
  logic                     busy;

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_pixel, out_last, busy
  );

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_pixel, out_last, busy
  );
endinterface

// File: rtl/idct_8x8_engine.sv
// Inverse 2-D 8x8 DCT by direct multiply-accumulate.
// Buffers one block of 64 coefficients, then for each output pixel runs
// 64 single-cycle MACs against a 9-bit cosine ROM, rounds, saturates and
// hands the pixel out before starting the next one.
module idct_8x8_engine #(
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 40
) (
  input logic               clk,
  input logic               rst_n,
  idct_8x8_engine_if.slave  bus
);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  // Basis table T[k][n] = round(256*a(k)*cos((2n+1)k*pi/16)), indexed {k, n}.
  localparam logic signed [8:0] T_ROM [64] = '{
     9'sd181,  9'sd181,  9'sd181,  9'sd181,  9'sd181,  9'sd181,  9'sd181,  9'sd181,
     9'sd251,  9'sd213,  9'sd142,  9'sd50,  -9'sd50,  -9'sd142, -9'sd213, -9'sd251,
     9'sd237,  9'sd98,  -9'sd98,  -9'sd237, -9'sd237, -9'sd98,   9'sd98,   9'sd237,
     9'sd213, -9'sd50,  -9'sd251, -9'sd142,  9'sd142,  9'sd251,  9'sd50,  -9'sd213,
     9'sd181, -9'sd181, -9'sd181,  9'sd181,  9'sd181, -9'sd181, -9'sd181,  9'sd181,
     9'sd142, -9'sd251,  9'sd50,   9'sd213, -9'sd213, -9'sd50,   9'sd251, -9'sd142,
     9'sd98,  -9'sd237,  9'sd237, -9'sd98,  -9'sd98,   9'sd237, -9'sd237,  9'sd98,
     9'sd50,  -9'sd142,  9'sd213, -9'sd251,  9'sd251, -9'sd213,  9'sd142, -9'sd50
  };

  // Two 8-bit fractional cosine factors give a 2^16 scale; the extra 2^2
  // folds in the 1/4 normalisation of the 2-D inverse transform.
  localparam int                      SHIFT = 18;
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << (SHIFT - 1);
  localparam longint                  PMAX_L = (longint'(1) << (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] PMAX  = ACC_W'(PMAX_L);
  localparam logic signed [ACC_W-1:0] PMIN  = ACC_W'(-PMAX_L - 1);

  state_t                   state;
  logic signed [COEF_W-1:0] coef_buf [64];
  logic [5:0]               cnt;   // coefficient index while loading, MAC index k while computing
  logic [5:0]               pix;   // current output pixel index n
  logic signed [ACC_W-1:0]  acc;

  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [OUT_W-1:0]  pixel_sat;

  // MAC datapath: X[k1][k2] * T[k1][n1] * T[k2][n2] added to the running sum,
  // with the final rounding and clamp applied to the updated sum.
  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    acc_next = ((cnt == 6'd0) ? '0 : acc)
             + ACC_W'(coef_buf[cnt])
             * ACC_W'(T_ROM[{cnt[5:3], pix[5:3]}])
             * ACC_W'(T_ROM[{cnt[2:0], pix[2:0]}]);
    rounded  = (acc_next + RND) >>> SHIFT;
    if (rounded > PMAX)      pixel_sat = OUT_W'(PMAX);
    else if (rounded < PMIN) pixel_sat = OUT_W'(PMIN);
    else                     pixel_sat = OUT_W'(rounded);
  end

  // Coefficient buffer: written only on an input handshake in LOAD.
  // NOTE: the buffer is a plain memory with no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && bus.in_valid && bus.in_ready) begin
      coef_buf[cnt] <= bus.in_coef;
    end
  end

  // Control FSM with registered stream outputs: load 64, then compute/emit 64 pixels.
  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_LOAD;
      cnt           <= '0;
      pix           <= '0;
      acc           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (bus.in_valid && bus.in_ready) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              state        <= S_COMPUTE;
              bus.in_ready <= 1'b0;
              bus.busy     <= 1'b1;
              pix          <= '0;
            end
          end
        end
        S_COMPUTE: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            state         <= S_OUTPUT;
            bus.out_pixel <= pixel_sat;
            bus.out_valid <= 1'b1;
            bus.out_last  <= (pix == 6'd63);
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            cnt           <= '0;
            if (pix == 6'd63) begin
              state        <= S_LOAD;
              pix          <= '0;
              bus.in_ready <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              pix   <= pix + 6'd1;
              state <= S_COMPUTE;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
